// File: rtl/vc_input_datapath_lock.sv
// Per-VC FWFT buffering with a selectable output arbiter and wormhole locking; RAVENOC_VC_CNT_EN adds vc_cnt_o.
// One cycle minimum input-to-output latency; fin_ready_o drops only when the addressed FIFO is full.
module vc_input_datapath_lock #(
    parameter int FLIT_WIDTH = 34,
    parameter int N_VIRT_CHN = 3,
    parameter int VC_DEPTH   = 4,
    parameter int ARB_MODE   = 0,
    parameter int VC_W       = $clog2(N_VIRT_CHN > 1 ? N_VIRT_CHN : 2)
) (
    input  logic                  clk,
    input  logic                  arst,
    input  logic [FLIT_WIDTH-1:0] fin_fdata_i,
    input  logic [VC_W-1:0]       fin_vc_id_i,
    input  logic                  fin_valid_i,
    output logic                  fin_ready_o,
    output logic [FLIT_WIDTH-1:0] fout_fdata_o,
    output logic [VC_W-1:0]       fout_vc_id_o,
    output logic                  fout_valid_o,
    input  logic                  fout_ready_i,
    output logic                  lock_o
`ifdef RAVENOC_VC_CNT_EN
    ,
    output logic [N_VIRT_CHN*($clog2(VC_DEPTH)+1)-1:0] vc_cnt_o
`endif
);

    localparam int PTR_W = $clog2(VC_DEPTH);
    localparam logic [PTR_W:0] PTR_ONE = (PTR_W+1)'(1);
    localparam logic [1:0] T_HEAD = 2'b00;
    localparam logic [1:0] T_BODY = 2'b01;
    localparam logic [1:0] T_TAIL = 2'b10;
    localparam logic [1:0] T_HT   = 2'b11;

    typedef enum logic {ST_UNLOCKED, ST_LOCKED} lock_state_t;

    logic [FLIT_WIDTH-1:0] mem    [N_VIRT_CHN][VC_DEPTH];
    logic [PTR_W:0]        wr_ptr [N_VIRT_CHN];
    logic [PTR_W:0]        rd_ptr [N_VIRT_CHN];

    logic [N_VIRT_CHN-1:0] empty, full, push, pop, elig;
    logic [VC_W-1:0]       arb_sel, sel, hold_vc, lock_vc, lock_vc_d, rr_ptr;
    logic [FLIT_WIDTH-1:0] head_dat;
    logic [1:0]            head_type;
    logic                  hold, xfer;
    lock_state_t           state, state_d;

    always_comb begin
        for (int i = 0; i < N_VIRT_CHN; i++) begin
            empty[i] = (wr_ptr[i] == rd_ptr[i]);
            full[i]  = (wr_ptr[i][PTR_W] != rd_ptr[i][PTR_W]) &&
                       (wr_ptr[i][PTR_W-1:0] == rd_ptr[i][PTR_W-1:0]);
        end
    end

    // Flits aimed at a VC that does not exist are accepted and discarded.
    always_comb begin
        fin_ready_o = 1'b1;
        push        = '0;
        for (int i = 0; i < N_VIRT_CHN; i++) begin
            if (fin_vc_id_i == VC_W'(i)) begin
                fin_ready_o = ~full[i];
                push[i]     = fin_valid_i & ~full[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < N_VIRT_CHN; i++) begin
            elig[i] = ~empty[i] & ((state == ST_UNLOCKED) || (lock_vc == VC_W'(i)));
        end
    end

    always_comb begin
        arb_sel = '0;
        if (ARB_MODE == 1) begin
            for (int i = N_VIRT_CHN - 1; i >= 0; i--) begin
                if (elig[i]) arb_sel = VC_W'(i);
            end
        end else if (ARB_MODE == 2) begin
            // Lowest eligible overall, overridden by the lowest eligible at or after rr_ptr.
            for (int i = N_VIRT_CHN - 1; i >= 0; i--) begin
                if (elig[i]) arb_sel = VC_W'(i);
            end
            for (int i = N_VIRT_CHN - 1; i >= 0; i--) begin
                if (elig[i] && (VC_W'(i) >= rr_ptr)) arb_sel = VC_W'(i);
            end
        end else begin
            for (int i = 0; i < N_VIRT_CHN; i++) begin
                if (elig[i]) arb_sel = VC_W'(i);
            end
        end
    end

    always_comb begin
        sel      = hold ? hold_vc : arb_sel;
        head_dat = '0;
        for (int i = 0; i < N_VIRT_CHN; i++) begin
            if (sel == VC_W'(i)) head_dat = mem[i][rd_ptr[i][PTR_W-1:0]];
        end
        head_type    = head_dat[FLIT_WIDTH-1 -: 2];
        fout_valid_o = |elig;
        fout_fdata_o = fout_valid_o ? head_dat : '0;
        fout_vc_id_o = fout_valid_o ? sel : '0;
        xfer         = fout_valid_o & fout_ready_i;
        pop          = '0;
        for (int i = 0; i < N_VIRT_CHN; i++) begin
            pop[i] = xfer && (sel == VC_W'(i));
        end
    end

    always_comb begin
        state_d   = state;
        lock_vc_d = lock_vc;
        lock_o    = (state == ST_LOCKED);
        case (state)
            ST_UNLOCKED: begin
                if (xfer && head_type == T_HEAD) begin
                    state_d   = ST_LOCKED;
                    lock_vc_d = sel;
                end
            end
            ST_LOCKED: begin
                if (xfer && head_type == T_TAIL && sel == lock_vc) state_d = ST_UNLOCKED;
            end
            default: state_d = ST_UNLOCKED;
        endcase
    end

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            state   <= ST_UNLOCKED;
            lock_vc <= '0;
            hold    <= 1'b0;
            hold_vc <= '0;
            rr_ptr  <= '0;
            for (int i = 0; i < N_VIRT_CHN; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
            end
        end else begin
            state   <= state_d;
            lock_vc <= lock_vc_d;
            hold    <= fout_valid_o & ~fout_ready_i;
            hold_vc <= sel;
            if (xfer && (head_type == T_TAIL || head_type == T_HT ||
                         (head_type == T_BODY && state == ST_UNLOCKED))) begin
                rr_ptr <= (sel == VC_W'(N_VIRT_CHN - 1)) ? '0 : sel + VC_W'(1);
            end
            for (int i = 0; i < N_VIRT_CHN; i++) begin
                if (push[i]) wr_ptr[i] <= wr_ptr[i] + PTR_ONE;
                if (pop[i])  rd_ptr[i] <= rd_ptr[i] + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < N_VIRT_CHN; i++) begin
            if (push[i]) mem[i][wr_ptr[i][PTR_W-1:0]] <= fin_fdata_i;
        end
    end

`ifdef RAVENOC_VC_CNT_EN
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    logic [CNT_W-1:0] cnt [N_VIRT_CHN];

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            for (int i = 0; i < N_VIRT_CHN; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < N_VIRT_CHN; i++) begin
                if (push[i] && !pop[i])      cnt[i] <= cnt[i] + CNT_ONE;
                else if (!push[i] && pop[i]) cnt[i] <= cnt[i] - CNT_ONE;
            end
        end
    end

    always_comb begin
        vc_cnt_o = '0;
        for (int i = 0; i < N_VIRT_CHN; i++) vc_cnt_o[i*CNT_W +: CNT_W] = cnt[i];
    end
`endif

endmodule
